aes_128_decrypt_iter: RTL and testbench



---
 rtl/aes_128_decrypt_iter.sv | 232 +++++++++++++++++++++++
 tb/tb_aes_128_decrypt_iter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_128_decrypt_iter.sv
// Iterative AES-128 decryption core: forward key expansion to rk10, then
// ten inverse rounds, one per clock, with the key schedule reversed in place.
// Optional macro AES_DEC_KEY_CACHE_EN: remembers the last key and its rk10 so a
// repeated key skips the 10-cycle expansion phase.
module aes_128_decrypt_iter #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ct,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] pt,
  output logic         busy
);

  if (NR != 10) begin : g_nr_check
    $error("aes_128_decrypt_iter: NR must be 10");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, KEYEXP = 2'd1, ROUND = 2'd2} fsm_e;

  // GF(2^8) arithmetic, polynomial 0x11b
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse (and maps 0 to 0)
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h01;
    x = a;
    for (int i = 1; i < 8; i++) begin
      x = gmul(x, x);
      r = gmul(r, x);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] i;
    i = ginv(a);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^
           {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return ginv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  fsm_e         fsm_q, fsm_d;
  logic [127:0] st_q, rk_q, pt_q;
  logic [7:0]   rcon_q, rcon_prev;
  logic [3:0]   cnt_q;
  logic         out_valid_q;
  logic         accept, cache_hit, keyexp_done, round_done;

  assign accept      = in_valid && in_ready;
  assign keyexp_done = (fsm_q == KEYEXP) && (cnt_q == 4'(NR));
  assign round_done  = (fsm_q == ROUND) && (cnt_q == 4'd0);
  assign rcon_prev   = (rcon_q == 8'h1b) ? 8'h80 : {1'b0, rcon_q[7:1]};

  // ---- key schedule: one forward or reverse step, 4 shared S-boxes ----
  logic [31:0]  w0, w1, w2, w3, rw1, rw2, rw3;
  logic [31:0]  sw_in, sw_rot, sw_out, g0;
  logic [127:0] rk_fwd, rk_rev;

  assign {w0, w1, w2, w3} = rk_q;
  assign rw3 = w3 ^ w2;
  assign rw2 = w2 ^ w1;
  assign rw1 = w1 ^ w0;
  // reverse step feeds the freshly recovered w3 into SubWord
  assign sw_in  = (fsm_q == ROUND) ? rw3 : w3;
  assign sw_rot = {sw_in[23:0], sw_in[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_fsbox
    assign sw_out[8*i +: 8] = sbox(sw_rot[8*i +: 8]);
  end

  assign g0     = w0 ^ sw_out ^ {rcon_q, 24'h0};
  assign rk_fwd = {g0, w1 ^ g0, w2 ^ w1 ^ g0, w3 ^ w2 ^ w1 ^ g0};
  assign rk_rev = {g0, rw1, rw2, rw3};

  // ---- inverse round datapath ----
  logic [127:0] isb, ark, imc;

  for (genvar b = 0; b < 16; b++) begin : g_isbox
    localparam int ROW = b % 4;
    localparam int SRC = ROW + 4 * (((b / 4) - ROW + 4) % 4);
    assign isb[127-8*b -: 8] = inv_sbox(st_q[127-8*SRC -: 8]);
  end

  assign ark = isb ^ rk_rev;

  for (genvar c = 0; c < 4; c++) begin : g_imc
    logic [7:0] a0, a1, a2, a3;
    assign a0 = ark[127-32*c -: 8];
    assign a1 = ark[119-32*c -: 8];
    assign a2 = ark[111-32*c -: 8];
    assign a3 = ark[103-32*c -: 8];
    assign imc[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
    assign imc[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
    assign imc[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
    assign imc[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
  end

  // ---- optional rk10 cache ----
`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] key_q, last_key_q, cached_rk10_q;
  logic         cache_vld_q;

  assign cache_hit = cache_vld_q && (key == last_key_q);

  // remember the key of the running expansion and its rk10 once it completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q         <= '0;
      last_key_q    <= '0;
      cached_rk10_q <= '0;
      cache_vld_q   <= 1'b0;
    end else begin
      if (accept) key_q <= key;
      if (keyexp_done) begin
        last_key_q    <= key_q;
        cached_rk10_q <= rk_fwd;
        cache_vld_q   <= 1'b1;
      end
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm_q <= IDLE;
    else        fsm_q <= fsm_d;
  end

  // FSM next-state
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (accept) fsm_d = cache_hit ? ROUND : KEYEXP;
      KEYEXP:  if (keyexp_done) fsm_d = ROUND;
      ROUND:   if (round_done) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready = (fsm_q == IDLE) && !out_valid_q;
    busy     = (fsm_q != IDLE);
  end

  // datapath: key steps, round state, counter, result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= '0;
      rk_q        <= '0;
      pt_q        <= '0;
      rcon_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (out_valid_q && out_ready) out_valid_q <= 1'b0;
          if (accept) begin
            // state register holds ct until rk10 is known
            st_q   <= ct;
            rk_q   <= key;
            rcon_q <= 8'h01;
            cnt_q  <= 4'd1;
`ifdef AES_DEC_KEY_CACHE_EN
            if (cache_hit) begin
              st_q   <= ct ^ cached_rk10_q;
              rk_q   <= cached_rk10_q;
              rcon_q <= 8'h36;
              cnt_q  <= 4'(NR - 1);
            end
`endif
          end
        end
        KEYEXP: begin
          rk_q <= rk_fwd;
          if (keyexp_done) begin
            st_q   <= st_q ^ rk_fwd;
            rcon_q <= 8'h36;
            cnt_q  <= 4'(NR - 1);
          end else begin
            rcon_q <= xtime(rcon_q);
            cnt_q  <= cnt_q + 4'd1;
          end
        end
        ROUND: begin
          rk_q   <= rk_rev;
          rcon_q <= rcon_prev;
          if (round_done) begin
            pt_q        <= ark;
            out_valid_q <= 1'b1;
          end else begin
            st_q  <= imc;
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign pt        = pt_q;

endmodule

// File: tb/tb_aes_128_decrypt_iter.sv
// Bench for aes_128_decrypt_iter: known-answer table, hold/garbage/reset
// sequences, key-cache latency, and random round trips through a forward
// AES-128 model.
module tb_aes_128_decrypt_iter;

`ifdef AES_DEC_KEY_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] ct, key, pt;

  int checks   = 0;
  int failures = 0;

  logic [7:0]   sb [256];
  logic         m_cache_vld;
  logic [127:0] m_last_key;

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;
  vec_t vecs [3];

  aes_128_decrypt_iter #(.NR(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ct(ct), .key(key), .out_valid(out_valid), .out_ready(out_ready),
    .pt(pt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box from walking the generator 3 and its inverse in lockstep
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ xt(p);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  // forward AES-128 encryption, byte-array style
  function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] p);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [7:0]   s [16];
    logic [7:0]   u [16];
    logic [127:0] r;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 16; j++) s[j] = p[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int j = 0; j < 16; j++) u[j] = sb[s[(j%4) + 4*(((j/4) + (j%4)) % 4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = u[4*c]; a1 = u[4*c+1]; a2 = u[4*c+2]; a3 = u[4*c+3];
        if (rnd < 10) begin
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int j = 0; j < 16; j++) s[j] = s[j] ^ w[4*rnd + j/4][31-8*(j%4) -: 8];
    end
    for (int j = 0; j < 16; j++) r[127-8*j -: 8] = s[j];
    return r;
  endfunction

  // one transaction; hold = cycles out_ready stays low after completion,
  // garbage_at > 0 pulses in_valid with junk at that cycle after accept
  task automatic run_txn(input logic [127:0] k, input logic [127:0] c, input logic [127:0] p,
                         input int hold, input int garbage_at, input string nm);
    int lat, exp_lat;
    exp_lat = (CACHE_EN && m_cache_vld && k == m_last_key) ? 11 : 21;
    @(negedge clk);
    chk({nm, " in_ready before accept"}, 128'(in_ready), 128'd1);
    in_valid  = 1'b1;
    key       = k;
    ct        = c;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    key      = {$urandom, $urandom, $urandom, $urandom};
    ct       = {$urandom, $urandom, $urandom, $urandom};
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        chk({nm, " busy after accept"}, 128'(busy), 128'd1);
        chk({nm, " in_ready while busy"}, 128'(in_ready), 128'd0);
      end
      if (garbage_at > 0 && lat == garbage_at) in_valid = 1'b1;
      if (garbage_at > 0 && lat == garbage_at + 1) in_valid = 1'b0;
    end while (!out_valid && lat < 60);
    in_valid = 1'b0;
    chk({nm, " latency"}, 128'(lat), 128'(exp_lat));
    chk({nm, " pt"}, pt, p);
    m_cache_vld = 1'b1;
    m_last_key  = k;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, " out_valid held"}, 128'(out_valid), 128'd1);
      chk({nm, " pt held"}, pt, p);
      chk({nm, " in_ready while held"}, 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk({nm, " out_valid cleared"}, 128'(out_valid), 128'd0);
    chk({nm, " in_ready after clear"}, 128'(in_ready), 128'd1);
    chk({nm, " pt kept"}, pt, p);
  endtask

  initial begin
    int           rises;
    logic [127:0] rk, rp, prev_k;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ct = '0; key = '0;
    m_cache_vld = 1'b0; m_last_key = '0;
    build_sbox();
    vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                128'h00112233445566778899aabbccddeeff};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
                128'h3243f6a8885a308d313198a2e0370734};
    vecs[2] = '{128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0};

    repeat (3) @(negedge clk);
    chk("reset in_ready", 128'(in_ready), 128'd1);
    chk("reset out_valid", 128'(out_valid), 128'd0);
    chk("reset pt", pt, 128'd0);
    chk("reset busy", 128'(busy), 128'd0);
    rst_n = 1'b1;

    // known-answer table
    for (int i = 0; i < 3; i++)
      run_txn(vecs[i].key, vecs[i].ct, vecs[i].pt, 0, 0, $sformatf("vec%0d", i));

    // backpressure hold and ignored in_valid while busy
    run_txn(vecs[1].key, vecs[1].ct, vecs[1].pt, 5, 0, "hold");
    run_txn(vecs[2].key, vecs[2].ct, vecs[2].pt, 0, 5, "garbage");

    // reset mid-operation aborts the transaction
    @(negedge clk);
    in_valid = 1'b1; key = vecs[0].key; ct = vecs[0].ct; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort out_valid", 128'(out_valid), 128'd0);
    chk("abort pt", pt, 128'd0);
    chk("abort busy", 128'(busy), 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_cache_vld = 1'b0;
    rises = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) rises++;
    end
    chk("abort no output", 128'(rises), 128'd0);
    chk("abort in_ready", 128'(in_ready), 128'd1);
    chk("abort pt stays 0", pt, 128'd0);
    run_txn(vecs[0].key, vecs[0].ct, vecs[0].pt, 0, 0, "reissue");

    // repeated key, then a different key
    run_txn(vecs[0].key, vecs[0].ct, vecs[0].pt, 0, 0, "cacheA1");
    run_txn(vecs[0].key, vecs[0].ct, vecs[0].pt, 0, 0, "cacheA2");
    run_txn(vecs[1].key, vecs[1].ct, vecs[1].pt, 0, 0, "cacheB");

    // random round trips, every third reuses the previous key
    prev_k = vecs[1].key;
    for (int i = 0; i < 8; i++) begin
      rk = (i % 3 == 2) ? prev_k : {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      run_txn(rk, aes_enc(rk, rp), rp, int'($urandom_range(0, 3)), 0, $sformatf("rand%0d", i));
      prev_k = rk;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
